// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier in the refclk domain.
// Drives the PLL reset, qualifies lock over a stability window, and counts losses and timeouts.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             clk_ready,
  output logic             lock_lost,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_T  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned TMR_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RESET = 2'b00,
    WAIT_LOCK = 2'b01,
    STABILIZE = 2'b10,
    RUNNING   = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [TMR_W-1:0]   r_timer;
  logic               r_sync1;
  logic               r_locked_s;
  logic               r_pll_rst;
  logic               r_clk_ready;
  logic               r_lock_lost;
  logic [CNT_W-1:0]   r_loss_cnt;
  logic [CNT_W-1:0]   r_timeout_cnt;
  logic               w_loss_inc;
  logic               w_timeout_inc;

  // relock_req outranks every lock-driven transition outside PLL_RESET.
  always_comb begin
    w_next        = r_state;
    w_loss_inc    = 1'b0;
    w_timeout_inc = 1'b0;
    case (r_state)
      PLL_RESET: begin
        if (r_timer == RST_LAST) w_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (relock_req) begin
          w_next = PLL_RESET;
        end else if (r_locked_s) begin
          w_next = STABILIZE;
        end else if (r_timer == TIMEOUT_LAST) begin
          w_next        = PLL_RESET;
          w_timeout_inc = 1'b1;
        end
      end
      STABILIZE: begin
        if (relock_req) begin
          w_next = PLL_RESET;
        end else if (!r_locked_s) begin
          w_next = WAIT_LOCK;
        end else if (r_timer == STABLE_LAST) begin
          w_next = RUNNING;
        end
      end
      RUNNING: begin
        if (relock_req) begin
          w_next = PLL_RESET;
        end else if (!r_locked_s) begin
          w_next     = WAIT_LOCK;
          w_loss_inc = 1'b1;
        end
      end
      default: w_next = PLL_RESET;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= PLL_RESET;
      r_timer       <= '0;
      r_sync1       <= 1'b0;
      r_locked_s    <= 1'b0;
      r_pll_rst     <= 1'b1;
      r_clk_ready   <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_loss_cnt    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
      r_state    <= w_next;
      if (w_next != r_state) r_timer <= '0;
      else                   r_timer <= r_timer + TMR_W'(1);
      r_pll_rst   <= (w_next == PLL_RESET);
      r_clk_ready <= (w_next == RUNNING);
      r_lock_lost <= w_loss_inc;
      if (w_loss_inc && (r_loss_cnt != '1))
        r_loss_cnt <= r_loss_cnt + CNT_W'(1);
      if (w_timeout_inc && (r_timeout_cnt != '1))
        r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign clk_ready   = r_clk_ready;
  assign lock_lost   = r_lock_lost;
  assign state       = r_state;
  assign loss_cnt    = r_loss_cnt;
  assign timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: stimulus queues expected output-change events (edge delay + value),
// a monitor pops one per observed change of the output vector.
module tb_pll_lock_supervisor;

  localparam int unsigned RST = 4;
  localparam int unsigned TO  = 20;
  localparam int unsigned ST  = 8;
  localparam int unsigned CW  = 2;

  // {state, pll_rst, clk_ready, lock_lost, loss_cnt, timeout_cnt}
  localparam logic [8:0] RESET_VEC = 9'b00_1_0_0_00_00;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          relock_req = 1'b0;
  logic          pll_rst;
  logic          clk_ready;
  logic          lock_lost;
  logic [1:0]    state;
  logic [CW-1:0] loss_cnt;
  logic [CW-1:0] timeout_cnt;
  logic [8:0]    w_vec;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(ST),
    .CNT_W        (CW)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .clk_ready  (clk_ready),
    .lock_lost  (lock_lost),
    .state      (state),
    .loss_cnt   (loss_cnt),
    .timeout_cnt(timeout_cnt)
  );

  always #5 refclk = ~refclk;

  assign w_vec = {state, pll_rst, clk_ready, lock_lost, loss_cnt, timeout_cnt};

  typedef struct {
    int unsigned d;
    logic [8:0]  v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  function automatic logic [8:0] mk(input int st, input int pr, input int cr,
                                    input int ll, input int lc, input int tc);
    return {st[1:0], pr[0], cr[0], ll[0], lc[1:0], tc[1:0]};
  endfunction

  task automatic push(input int unsigned d, input logic [8:0] v, input string name);
    exp_t e;
    e.d = d;
    e.v = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  task automatic check_vec(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Monitor: counts rising edges since the last output change, compares on each change.
  initial begin
    logic [8:0]  prev;
    int unsigned delta;
    exp_t        e;
    prev  = RESET_VEC;
    delta = 0;
    forever begin
      @(posedge refclk);
      if (mon_on) delta++;
      @(negedge refclk);
      if (mon_on && (w_vec !== prev)) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_change: got %b after %0d edges, required no change", w_vec, delta);
        end else begin
          e = q.pop_front();
          n_checks++;
          if (delta != e.d) begin
            n_fail++;
            $display("FAIL %s_delay: got %0d edges required %0d", e.name, delta, e.d);
          end
          check_vec(e.name, w_vec, e.v);
        end
        prev  = w_vec;
        delta = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    pll_locked = 1'b1;
    relock_req = 1'b0;
    cycles(3);
    check_vec("reset_vec", w_vec, RESET_VEC);

    // Clean lock: 4 reset edges, one WAIT_LOCK edge, 8 stabilize edges.
    push(4, mk(1, 0, 0, 0, 0, 0), "A_wait");
    push(1, mk(2, 0, 0, 0, 0, 0), "A_stab");
    push(8, mk(3, 0, 1, 0, 0, 0), "A_run");
    rst_n  = 1'b1;
    mon_on = 1'b1;
    cycles(20);

    // Loss while RUNNING, then relock.
    push(10, mk(1, 0, 0, 1, 1, 0), "D_lost");
    push(1,  mk(1, 0, 0, 0, 1, 0), "D_wait");
    push(4,  mk(2, 0, 0, 0, 1, 0), "D_stab");
    push(8,  mk(3, 0, 1, 0, 1, 0), "D_run");
    pll_locked = 1'b0;
    cycles(5);
    pll_locked = 1'b1;
    cycles(15);

    // Relock request on the first cycle locked_s reads 0.
    push(7, mk(0, 1, 0, 0, 1, 0), "E_reset");
    push(4, mk(1, 0, 0, 0, 1, 0), "E_wait");
    pll_locked = 1'b0;
    cycles(2);
    relock_req = 1'b1;
    cycles(1);
    relock_req = 1'b0;

    // Glitch during STABILIZE at stabilize count 5.
    push(1, mk(2, 0, 0, 0, 1, 0), "C_stab");
    push(6, mk(1, 0, 0, 0, 1, 0), "C_glitch");
    push(3, mk(2, 0, 0, 0, 1, 0), "C_restab");
    push(8, mk(3, 0, 1, 0, 1, 0), "C_run");
    pll_locked = 1'b1;
    cycles(8);
    pll_locked = 1'b0;
    cycles(3);
    pll_locked = 1'b1;

    // Relock (held into PLL_RESET, where it is ignored), then async reset mid-STABILIZE.
    push(2, mk(0, 1, 0, 0, 1, 0), "F_relock");
    push(4, mk(1, 0, 0, 0, 1, 0), "F_wait");
    push(1, mk(2, 0, 0, 0, 1, 0), "F_stab");
    push(2, RESET_VEC,            "F_async");
    push(4, mk(1, 0, 0, 0, 0, 0), "F_wait2");
    push(1, mk(2, 0, 0, 0, 0, 0), "F_stab2");
    push(8, mk(3, 0, 1, 0, 0, 0), "F_run2");
    cycles(12);
    relock_req = 1'b1;
    cycles(2);
    relock_req = 1'b0;
    cycles(6);
    rst_n = 1'b0;
    #1;
    check_vec("F_async_immediate", w_vec, RESET_VEC);
    #1;
    rst_n = 1'b1;
    cycles(15);

    // Never locks: five timeouts, counter saturates at 3.
    push(2, RESET_VEC,            "B_reset");
    push(6, mk(1, 0, 0, 0, 0, 0), "B_wait");
    for (int k = 1; k <= 5; k++) begin
      push(20, mk(0, 1, 0, 0, 0, (k > 3) ? 3 : k), $sformatf("B_timeout%0d", k));
      push(4,  mk(1, 0, 0, 0, 0, (k > 3) ? 3 : k), $sformatf("B_rewait%0d", k));
    end
    pll_locked = 1'b0;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(126);

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d events outstanding, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
